mux_scan_ctrl: RTL and testbench

Sequencer that drives the 2-bit `select` of the 4:1 dataflow mux and collects its single-bit output `O` back into a parallel 4-bit word. It steps `select` through 0..3, waits a programmable settle time per channel, samples the mux output, and publishes the assembled word with a one-cycle `done` pulse. It sits on both sides of the mux: its `select` output feeds the mux, and the mux output `O` returns on `mux_out`.

---
 rtl/mux_scan_ctrl.sv | 73 +++++++
 tb/tb_mux_scan_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 mux: steps select 0..3 with a settle delay per channel,
// gathers the mux output bits and publishes them as one 4-bit word with a done pulse.
module mux_scan_ctrl #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       continuous,
    input  logic       mux_out,
    output logic [1:0] select,
    output logic       busy,
    output logic       done,
    output logic [3:0] sample
);

    typedef enum logic {IDLE, SCAN} state_t;

    localparam logic [3:0] SET = 4'(SETTLE);

    state_t     state;
    logic [3:0] cnt;
    logic [3:0] shadow;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            select <= 2'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sample <= 4'd0;
            cnt    <= 4'd0;
            shadow <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        state  <= SCAN;
                        select <= 2'd0;
                        cnt    <= SET;
                        busy   <= 1'b1;
                    end
                end
                SCAN: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        shadow[select] <= mux_out;
                        if (select != 2'd3) begin
                            select <= select + 2'd1;
                            cnt    <= SET;
                        end else begin
                            // Final channel goes straight into the word so all bits land together.
                            sample <= {mux_out, shadow[2:0]};
                            done   <= 1'b1;
                            select <= 2'd0;
                            if (continuous) begin
                                cnt <= SET;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Randomized check of mux_scan_ctrl at four settle values against a timing-based reference model.
module tb_mux_scan_ctrl;

    localparam int N = 4;
    localparam int SV[N] = '{0, 1, 2, 15};

    logic       clk = 1'b0;
    logic       reset, start, continuous;
    logic [3:0] din;

    logic [1:0] sel[N];
    logic       busy[N], done[N], mo[N];
    logic [3:0] smp[N];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        assign mo[g] = din[sel[g]];
        mux_scan_ctrl #(.SETTLE(SV[g])) u_dut (
            .clk       (clk),
            .reset     (reset),
            .start     (start),
            .continuous(continuous),
            .mux_out   (mo[g]),
            .select    (sel[g]),
            .busy      (busy[g]),
            .done      (done[g]),
            .sample    (smp[g])
        );
    end

    // Model: elapsed cycles since start acceptance determine channel and capture points.
    bit         act[N];
    int         el[N];
    logic [3:0] shd[N], m_smp[N];
    bit         m_done[N];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        for (int g = 0; g < N; g++) begin
            int p = SV[g] + 1;
            if (reset) begin
                act[g] = 0; el[g] = 0; shd[g] = 0; m_smp[g] = 0; m_done[g] = 0;
            end else if (!act[g]) begin
                m_done[g] = 0;
                if (start) begin act[g] = 1; el[g] = 0; end
            end else begin
                el[g]++;
                m_done[g] = 0;
                if (el[g] % p == 0) shd[g][el[g]/p - 1] = din[el[g]/p - 1];
                if (el[g] == 4 * p) begin
                    m_smp[g]  = shd[g];
                    m_done[g] = 1;
                    el[g]     = 0;
                    if (!continuous) act[g] = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int g = 0; g < N; g++) begin
            int p = SV[g] + 1;
            chk($sformatf("select[S=%0d]", SV[g]), 32'(sel[g]), act[g] ? 32'(el[g] / p) : 32'd0);
            chk($sformatf("busy[S=%0d]", SV[g]), 32'(busy[g]), 32'(act[g]));
            chk($sformatf("done[S=%0d]", SV[g]), 32'(done[g]), 32'(m_done[g]));
            chk($sformatf("sample[S=%0d]", SV[g]), 32'(smp[g]), 32'(m_smp[g]));
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1 check_all();
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; continuous = 1'b0; din = 4'd0;
        for (int g = 0; g < N; g++) begin
            act[g] = 0; el[g] = 0; shd[g] = 0; m_smp[g] = 0; m_done[g] = 0;
        end
        @(negedge clk);
        step(2);
        reset = 1'b0;
        step(5);

        // single shot
        din = 4'b1010; start = 1'b1; step(1); start = 1'b0;
        step(70);

        // continuous, pattern change, then drop continuous
        din = 4'b0110; continuous = 1'b1; start = 1'b1; step(1); start = 1'b0;
        step(6);
        din = 4'b1001;
        step(30);
        continuous = 1'b0;
        step(70);

        // start held through whole scans
        din = 4'b0011; start = 1'b1; step(40); start = 1'b0;
        step(70);

        // reset mid-scan then a fresh scan
        din = 4'b1111; start = 1'b1; step(1); start = 1'b0;
        step(4);
        reset = 1'b1; step(1); reset = 1'b0;
        step(3);
        start = 1'b1; step(1); start = 1'b0;
        step(70);

        // long settle with a single set bit
        din = 4'b0001; start = 1'b1; step(1); start = 1'b0;
        step(70);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom % 4) == 0;
            if (($urandom % 40) == 0) continuous = ~continuous;
            if (($urandom % 6) == 0) din = 4'($urandom);
            reset = ($urandom % 300) == 0;
            step(1);
        end
        reset = 1'b0; start = 1'b0; continuous = 1'b0;
        step(70);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
